// File: rtl/audio_playback.sv
// audio_playback: FIFO-buffered 12-bit sample playback, one sample per tick, to a 1-bit speaker modulator.
// Define AUDIO_SIGMA_DELTA_EN to replace the default 8-bit PWM with a first-order sigma-delta modulator.
module audio_playback #(
  parameter int SAMPLE_W    = 12,
  parameter int FIFO_AW     = 4,
  parameter int SAMPLE_DIV  = 3125,
  parameter int PRIME_LEVEL = 8
) (
  input  logic                CLOCK_50,
  input  logic                RESET,
  input  logic                enable,
  input  logic                flush,
  input  logic [SAMPLE_W-1:0] s_data,
  input  logic                s_valid,
  output logic                s_ready,
  output logic [FIFO_AW:0]    fifo_level,
  output logic                playing,
  output logic                underrun,
  output logic                speaker
);
  localparam int DEPTH = 1 << FIFO_AW;
  localparam int CW = $clog2(SAMPLE_DIV);
  typedef enum logic [1:0] {IDLE, PRIME, PLAY} state_t;
  state_t state_q, state_d;
  logic [SAMPLE_W-1:0] mem_q [DEPTH];
  logic [FIFO_AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [FIFO_AW:0] lvl_q, lvl_d;
  logic [CW-1:0] div_q, div_d;
  logic [SAMPLE_W-1:0] cur_sample_q, cur_sample_d;
  logic underrun_q, underrun_d;
  logic tick, push, pop;
  assign s_ready = !lvl_q[FIFO_AW];
  assign fifo_level = lvl_q;
  assign playing = state_q == PLAY;
  assign underrun = underrun_q;
  assign tick = state_q == PLAY && div_q == CW'(SAMPLE_DIV - 1);
  assign push = s_valid && s_ready && !flush;
  // flush beats both push and pop; an underrun tick never bypasses a same-cycle push
  assign pop = tick && lvl_q != '0 && !flush;
  always_comb begin
    state_d = !enable ? IDLE :
              state_q == IDLE ? PRIME :
              (state_q == PRIME && lvl_q >= (FIFO_AW+1)'(PRIME_LEVEL)) ? PLAY : state_q;
    div_d = (state_q != PLAY || tick) ? '0 : div_q + 1'b1;
    wr_d = flush ? '0 : wr_q + FIFO_AW'(push);
    rd_d = flush ? '0 : rd_q + FIFO_AW'(pop);
    lvl_d = flush ? '0 : lvl_q + (FIFO_AW+1)'(push) - (FIFO_AW+1)'(pop);
    cur_sample_d = pop ? mem_q[rd_q] : cur_sample_q;
    underrun_d = tick && lvl_q == '0;
  end
  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      state_q <= IDLE;
      wr_q <= '0;
      rd_q <= '0;
      lvl_q <= '0;
      div_q <= '0;
      cur_sample_q <= {1'b1, {(SAMPLE_W-1){1'b0}}};
      underrun_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wr_q <= wr_d;
      rd_q <= rd_d;
      lvl_q <= lvl_d;
      div_q <= div_d;
      cur_sample_q <= cur_sample_d;
      underrun_q <= underrun_d;
    end
  end
  always_ff @(posedge CLOCK_50) begin
    if (push) mem_q[wr_q] <= s_data;
  end
`ifdef AUDIO_SIGMA_DELTA_EN
  logic [SAMPLE_W:0] acc_q, acc_d;
  assign acc_d = state_q == IDLE ? '0 : {1'b0, acc_q[SAMPLE_W-1:0]} + {1'b0, cur_sample_q};
  assign speaker = acc_q[SAMPLE_W];
  always_ff @(posedge CLOCK_50) begin
    if (RESET) acc_q <= '0;
    else acc_q <= acc_d;
  end
`else
  logic [7:0] pwm_q, pwm_d;
  logic speaker_q, speaker_d;
  assign pwm_d = state_q == IDLE ? '0 : pwm_q + 8'd1;
  assign speaker_d = state_q != IDLE && pwm_q < cur_sample_q[SAMPLE_W-1 -: 8];
  assign speaker = speaker_q;
  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      pwm_q <= '0;
      speaker_q <= 1'b0;
    end else begin
      pwm_q <= pwm_d;
      speaker_q <= speaker_d;
    end
  end
`endif
endmodule

// File: tb/tb_audio_playback.sv
// tb_audio_playback: directed phases with random sample data, checked every cycle against a queue-based model.
module tb_audio_playback;
  localparam int DIV = 300;
  localparam int PL = 8;
  logic CLOCK_50 = 1'b0;
  logic RESET = 1'b1, enable = 1'b0, flush = 1'b0, s_valid = 1'b0;
  logic [11:0] s_data = '0;
  logic s_ready, playing, underrun, speaker;
  logic [4:0] fifo_level;
  int n_chk = 0, n_fail = 0, n_under_seen = 0, hi = 0;
  logic [11:0] s8;
  int q[$];
  int m_mode = 0;
  int m_phase = 0, m_pwm = 0, m_cur = 'h800;
  bit m_under = 1'b0, m_spk = 1'b0;

  audio_playback #(.SAMPLE_DIV(DIV), .PRIME_LEVEL(PL)) dut (
    .CLOCK_50(CLOCK_50), .RESET(RESET), .enable(enable), .flush(flush),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready), .fifo_level(fifo_level),
    .playing(playing), .underrun(underrun), .speaker(speaker)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // mode: 0 idle, 1 priming, 2 playing; the FIFO is a plain queue of samples
  task automatic model();
    int n = q.size();
    bit tick = m_mode == 2 && m_phase == DIV - 1;
    if (RESET) begin
      q.delete();
      m_mode = 0; m_phase = 0; m_pwm = 0; m_cur = 'h800; m_under = 1'b0; m_spk = 1'b0;
      return;
    end
    m_under = tick && n == 0;
    m_spk = m_mode != 0 && m_pwm < (m_cur >> 4);
    if (flush) q.delete();
    else begin
      if (tick && n > 0) m_cur = q.pop_front();
      if (s_valid && n < 16) q.push_back(int'(s_data));
    end
    m_phase = (m_mode == 2 && !tick) ? m_phase + 1 : 0;
    m_pwm = m_mode == 0 ? 0 : (m_pwm + 1) % 256;
    m_mode = !enable ? 0 : m_mode == 0 ? 1 : (m_mode == 1 && n >= PL) ? 2 : m_mode;
  endtask

  task automatic cyc();
    model();
    @(posedge CLOCK_50);
    #1;
    if (underrun === 1'b1) n_under_seen++;
    chk("level", 32'(fifo_level), 32'(q.size()));
    chk("ready", 32'(s_ready), 32'(q.size() < 16));
    chk("playing", 32'(playing), 32'(m_mode == 2));
    chk("underrun", 32'(underrun), 32'(m_under));
    chk("cur_sample", 32'(dut.cur_sample_q), 32'(m_cur));
`ifndef AUDIO_SIGMA_DELTA_EN
    chk("speaker", 32'(speaker), 32'(m_spk));
`endif
  endtask

  initial begin
    s_valid = 1'b1;
    s_data = 12'($urandom);
    repeat (2) cyc();
    chk("rst_level", 32'(fifo_level), 0);
    chk("rst_ready", 32'(s_ready), 1);
    chk("rst_speaker", 32'(speaker), 0);
    RESET = 1'b0;
    for (int i = 0; i < 17; i++) begin
      s_data = 12'($urandom);
      cyc();
    end
    s_valid = 1'b0;
    chk("full_level", 32'(fifo_level), 16);
    chk("full_ready", 32'(s_ready), 0);
    enable = 1'b1;
    repeat (17 * DIV + 20) cyc();
    chk("underrun_count_a", 32'(n_under_seen), 1);
    enable = 1'b0;
    repeat (3) cyc();
    chk("idle_speaker", 32'(speaker), 0);
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    enable = 1'b1;
    s_valid = 1'b1;
    for (int i = 0; i < 7; i++) begin
      s_data = 12'($urandom);
      cyc();
    end
    s_valid = 1'b0;
    repeat (20) cyc();
    chk("prime_hold", 32'(playing), 0);
    s_valid = 1'b1;
    s_data = 12'($urandom);
    s8 = s_data;
    cyc();
    s_valid = 1'b0;
    chk("prime_level", 32'(fifo_level), 8);
    chk("prime_not_yet", 32'(playing), 0);
    cyc();
    chk("prime_play", 32'(playing), 1);
    repeat (9 * DIV + 5) cyc();
    chk("underrun_count_b", 32'(n_under_seen), 2);
    chk("hold_cur", 32'(dut.cur_sample_q), 32'(s8));
    chk("still_playing", 32'(playing), 1);
    enable = 1'b0;
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    s_valid = 1'b1;
    s_data = 12'hC00;
    repeat (8) cyc();
    s_valid = 1'b0;
    enable = 1'b1;
    repeat (DIV + 5) cyc();
`ifdef AUDIO_SIGMA_DELTA_EN
    for (int i = 0; i < 4096; i++) begin
      cyc();
      if (speaker === 1'b1) hi++;
    end
    chk("sd_density", 32'(hi >= 3071 && hi <= 3073), 1);
`else
    for (int i = 0; i < 256; i++) begin
      cyc();
      if (speaker === 1'b1) hi++;
    end
    chk("pwm_duty", 32'(hi), 192);
`endif
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    for (int i = 0; i < DIV && m_phase != 10; i++) cyc();
    s_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      s_data = 12'($urandom);
      cyc();
    end
    s_valid = 1'b0;
    for (int i = 0; i < DIV && m_phase != DIV - 1; i++) cyc();
    chk("pre_flush_level", 32'(fifo_level), 5);
    flush = 1'b1;
    s_valid = 1'b1;
    s_data = 12'($urandom);
    cyc();
    flush = 1'b0;
    s_valid = 1'b0;
    chk("flush_level", 32'(fifo_level), 0);
    chk("flush_cur", 32'(dut.cur_sample_q), 32'h C00);
    chk("flush_no_underrun", 32'(underrun), 0);
    s_valid = 1'b1;
    repeat (3) begin
      s_data = 12'($urandom);
      cyc();
    end
    s_valid = 1'b0;
    RESET = 1'b1;
    cyc();
    RESET = 1'b0;
    chk("midrst_level", 32'(fifo_level), 0);
    chk("midrst_playing", 32'(playing), 0);
    chk("midrst_cur", 32'(dut.cur_sample_q), 32'h800);
    for (int i = 0; i < 3000; i++) begin
      s_valid = 1'($urandom_range(0, 1));
      s_data = 12'($urandom);
      flush = $urandom_range(0, 99) == 0;
      if ($urandom_range(0, 499) == 0) enable = !enable;
      cyc();
    end
    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end
endmodule
